// File: rtl/tagger_cfg_ctrl.sv
// Programs a partition table into the tagger register block, then commits it and polls until the commit settles.
// Latency: one cycle per register transfer with ready high; done_o is a registered pulse one cycle after the final poll read.
// Backpressure: each request is held stable until reg_rsp_i.ready; cfg_ready_o is high only while idle.
package tagger_cfg_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module tagger_cfg_ctrl #(
    parameter int unsigned MAXPARTITION = 2,
    parameter int unsigned PATID_LEN    = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [31:0] COMMIT_OFF   = 32'h0,
    parameter logic [31:0] PAT_ADDR_OFF = 32'h4,
    parameter logic [31:0] PATID_OFF    = 32'hC,
    parameter logic [31:0] CONF_OFF     = 32'h10,
    parameter int unsigned POLL_MAX     = 16,
    parameter type reg_req_t = tagger_cfg_pkg::reg_req_t,
    parameter type reg_rsp_t = tagger_cfg_pkg::reg_rsp_t
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 cfg_valid_i,
    output logic                                 cfg_ready_o,
    input  logic [MAXPARTITION-1:0][31:0]        cfg_addr_i,
    input  logic [MAXPARTITION-1:0][PATID_LEN-1:0] cfg_patid_i,
    input  logic [MAXPARTITION-1:0][1:0]         cfg_conf_i,
    output reg_req_t                             reg_req_o,
    input  reg_rsp_t                             reg_rsp_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o
);
    localparam int unsigned NE     = 32 / PATID_LEN;
    localparam int unsigned NPR    = (MAXPARTITION + NE - 1) / NE;
    localparam int unsigned NCR    = (MAXPARTITION + 15) / 16;
    localparam int unsigned MAXCNT = (MAXPARTITION > POLL_MAX) ? MAXPARTITION : POLL_MAX;
    localparam int unsigned CW     = $clog2(MAXCNT + 1);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_PATID, WR_CONF, WR_COMMIT, POLL} state_e;

    state_e state_q, state_d, state_nxt;
    logic [CW-1:0] idx_q, idx_d;
    logic error_q, error_d, done_q, done_d;
    logic xfer, last;

    logic [MAXPARTITION-1:0][31:0]          addr_q;
    logic [MAXPARTITION-1:0][PATID_LEN-1:0] patid_q;
    logic [MAXPARTITION-1:0][1:0]           conf_q;

    logic [31:0] pat_word  [NPR];
    logic [31:0] conf_word [NCR];
    logic [31:0] addr_sel, pat_sel, conf_sel;

    // Register images are built at elaboration so slots past the last partition are tied to zero.
    for (genvar i = 0; i < NPR; i++) begin : g_pat
        for (genvar j = 0; j < NE; j++) begin : g_slot
            if (i * NE + j < MAXPARTITION) begin : g_used
                assign pat_word[i][PATID_LEN*j +: PATID_LEN] = patid_q[i*NE+j];
            end else begin : g_unused
                assign pat_word[i][PATID_LEN*j +: PATID_LEN] = '0;
            end
        end
        if (NE * PATID_LEN < 32) begin : g_pad
            assign pat_word[i][31:NE*PATID_LEN] = '0;
        end
    end

    for (genvar i = 0; i < NCR; i++) begin : g_conf
        for (genvar j = 0; j < 16; j++) begin : g_slot
            if (i * 16 + j < MAXPARTITION) begin : g_used
                assign conf_word[i][2*j +: 2] = conf_q[i*16+j];
            end else begin : g_unused
                assign conf_word[i][2*j +: 2] = 2'b00;
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        pat_sel  = '0;
        conf_sel = '0;
        for (int k = 0; k < MAXPARTITION; k++) if (idx_q == CW'(k)) addr_sel = addr_q[k];
        for (int k = 0; k < NPR; k++)          if (idx_q == CW'(k)) pat_sel  = pat_word[k];
        for (int k = 0; k < NCR; k++)          if (idx_q == CW'(k)) conf_sel = conf_word[k];
    end

    always_comb begin
        state_d   = state_q;
        state_nxt = IDLE;
        idx_d     = idx_q;
        error_d   = error_q;
        done_d    = 1'b0;
        last      = 1'b0;
        reg_req_o = '0;
        xfer      = (state_q != IDLE) && reg_rsp_i.ready;

        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    state_d = WR_ADDR;
                    idx_d   = '0;
                    error_d = 1'b0;
                end
            end
            WR_ADDR: begin
                reg_req_o.addr  = BASE_ADDR + PAT_ADDR_OFF + (32'(idx_q) << 2);
                reg_req_o.write = 1'b1;
                reg_req_o.wdata = addr_sel;
                last            = (idx_q == CW'(MAXPARTITION - 1));
                state_nxt       = WR_PATID;
            end
            WR_PATID: begin
                reg_req_o.addr  = BASE_ADDR + PATID_OFF + (32'(idx_q) << 2);
                reg_req_o.write = 1'b1;
                reg_req_o.wdata = pat_sel;
                last            = (idx_q == CW'(NPR - 1));
                state_nxt       = WR_CONF;
            end
            WR_CONF: begin
                reg_req_o.addr  = BASE_ADDR + CONF_OFF + (32'(idx_q) << 2);
                reg_req_o.write = 1'b1;
                reg_req_o.wdata = conf_sel;
                last            = (idx_q == CW'(NCR - 1));
                state_nxt       = WR_COMMIT;
            end
            WR_COMMIT: begin
                reg_req_o.addr  = BASE_ADDR + COMMIT_OFF;
                reg_req_o.write = 1'b1;
                reg_req_o.wdata = 32'h1;
                last            = 1'b1;
                state_nxt       = POLL;
            end
            POLL: begin
                reg_req_o.addr  = BASE_ADDR + COMMIT_OFF;
                last            = (idx_q == CW'(POLL_MAX - 1));
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            reg_req_o.valid = 1'b1;
            reg_req_o.wstrb = 4'hF;
        end

        if (xfer) begin
            if (reg_rsp_i.error) begin
                error_d = 1'b1;
                state_d = IDLE;
            end else if (state_q == POLL) begin
                if (!reg_rsp_i.rdata[0]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (last) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end else if (last) begin
                state_d = state_nxt;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            patid_q <= '0;
            conf_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            error_q <= error_d;
            done_q  <= done_d;
            if (state_q == IDLE && cfg_valid_i) begin
                addr_q  <= cfg_addr_i;
                patid_q <= cfg_patid_i;
                conf_q  <= cfg_conf_i;
            end
        end
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign error_o     = error_q;
endmodule
